instruction_fetch: RTL

Pipeline front end of the RV32I core: owns the program counter and issues word fetches to instruction memory over a request/grant/response handshake. It buffers returned instructions, each tagged with its PC, in a small in-order queue. It presents them to `instruction_decode` on `o_if_inst`/`o_if_pc`, which decode consumes as `i_if_inst`/`i_if_pc`. Taken branches and jumps from execute redirect the PC, discard everything buffered and in flight, and restart fetch at the target.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/if_fifo.sv | 116 +++++++++++
 rtl/instruction_fetch.sv | 105 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I front end: datapath width, the canonical
// NOP encoding and the {pc, inst} entry carried from fetch to decode.
package riscv_pkg;

  localparam int DATA_WIDTH = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [31:0]           inst;
  } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// In-order instruction queue. Each granted fetch reserves a slot and parks its
// PC there; the matching response fills in the instruction word. Only filled
// slots are visible to decode. The head entry is held in output registers so
// decode never sees a combinational path from the memory or decode inputs.
module if_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   reserve_i,
  input  logic [DATA_WIDTH-1:0]  reserve_pc_i,
  input  logic                   fill_i,
  input  logic [31:0]            fill_inst_i,
  input  logic                   pop_i,
  output logic                   head_valid_o,
  output if_entry_t              head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W:0] ptr_t;

  // Pointer order is rd <= fill <= resv: [rd, fill) holds complete entries,
  // [fill, resv) holds PC-tagged slots still waiting for their response.
  ptr_t      rd_q, rd_d;
  ptr_t      fill_q, fill_d;
  ptr_t      resv_q, resv_d;
  if_entry_t mem_q [DEPTH];
  logic      head_valid_q, head_valid_d;
  if_entry_t head_q, head_d;
  logic      pop_s;

  assign pop_s        = pop_i & head_valid_q;
  assign head_valid_o = head_valid_q;
  assign head_o       = head_q;
  assign count_o      = fill_q - rd_q;

  // Next pointers and the next head entry, forwarding a response that lands
  // directly in the head slot so a returned word reaches decode one cycle later.
  always_comb begin
    rd_d         = rd_q;
    fill_d       = fill_q;
    resv_d       = resv_q;
    head_valid_d = 1'b0;
    head_d       = '{pc: '0, inst: NOP_INST};
    if (clear_i) begin
      rd_d   = '0;
      fill_d = '0;
      resv_d = '0;
    end else begin
      if (pop_s) begin
        rd_d = rd_q + ptr_t'(1);
      end else begin
        rd_d = rd_q;
      end
      if (fill_i) begin
        fill_d = fill_q + ptr_t'(1);
      end else begin
        fill_d = fill_q;
      end
      if (reserve_i) begin
        resv_d = resv_q + ptr_t'(1);
      end else begin
        resv_d = resv_q;
      end
      if (fill_d != rd_d) begin
        head_valid_d = 1'b1;
        if (fill_i && (fill_q == rd_d)) begin
          head_d = '{pc: mem_q[rd_d[PTR_W-1:0]].pc, inst: fill_inst_i};
        end else begin
          head_d = mem_q[rd_d[PTR_W-1:0]];
        end
      end else begin
        head_valid_d = 1'b0;
      end
    end
  end

  // Pointer and head-register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q         <= '0;
      fill_q       <= '0;
      resv_q       <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '{pc: '0, inst: NOP_INST};
    end else begin
      rd_q         <= rd_d;
      fill_q       <= fill_d;
      resv_q       <= resv_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  // Slot storage: PC tag written at grant, instruction word written at response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{pc: '0, inst: NOP_INST};
      end
    end else begin
      if (reserve_i && !clear_i) begin
        mem_q[resv_q[PTR_W-1:0]].pc <= reserve_pc_i;
      end
      if (fill_i && !clear_i) begin
        mem_q[fill_q[PTR_W-1:0]].inst <= fill_inst_i;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Front end of the RV32I pipeline: owns the fetch PC, issues word fetches under
// a credit limit so the queue can never overflow, discards responses that belong
// to a path abandoned by a redirect, and hands in-order instructions to decode.
module instruction_fetch #(
  parameter int                         DATA_WIDTH = riscv_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0]      RESET_PC   = 32'h0000_0000,
  parameter int                         FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_id_ready,
  input  logic                  i_ex_redirect,
  input  logic [DATA_WIDTH-1:0] i_ex_target,
  output logic                  o_imem_req,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_gnt,
  input  logic                  i_imem_rvalid,
  input  logic [31:0]           i_imem_rdata,
  output logic                  o_if_valid,
  output logic [31:0]           o_if_inst,
  output logic [DATA_WIDTH-1:0] o_if_pc
);

  import riscv_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic [CNT_W-1:0]      kill_q, kill_d;
  logic [CNT_W-1:0]      queue_count_s;
  logic [CNT_W:0]        credit_used_s;
  logic                  grant_s;
  logic                  kill_active_s;
  logic                  keep_s;
  logic                  drop_s;
  if_entry_t             head_s;

  assign grant_s       = o_imem_req & i_imem_gnt;
  assign kill_active_s = (kill_q != '0);
  assign keep_s        = i_imem_rvalid & ~kill_active_s;
  assign drop_s        = i_imem_rvalid & kill_active_s;
  assign o_imem_addr   = fetch_pc_q;
  assign o_if_inst     = head_s.inst;
  assign o_if_pc       = head_s.pc;

  // Issue only while every in-flight request still has a free queue slot.
  always_comb begin
    credit_used_s = {1'b0, outstanding_q} + {1'b0, queue_count_s};
    if (rst) begin
      o_imem_req = 1'b0;
    end else begin
      o_imem_req = (credit_used_s < (CNT_W+1)'(FIFO_DEPTH));
    end
  end

  // Next PC, in-flight count and kill count; a redirect turns everything still
  // in flight (including a request granted in the same cycle) into kill credit.
  always_comb begin
    outstanding_d = outstanding_q + CNT_W'(grant_s) - CNT_W'(i_imem_rvalid);
    fetch_pc_d    = fetch_pc_q;
    kill_d        = kill_q;
    if (i_ex_redirect) begin
      fetch_pc_d = {i_ex_target[DATA_WIDTH-1:2], 2'b00};
      kill_d     = outstanding_d;
    end else begin
      if (grant_s) begin
        fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      kill_d = kill_q - CNT_W'(drop_s);
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      kill_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
    end
  end

  if_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_if_fifo (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (i_ex_redirect),
    .reserve_i    (grant_s & ~i_ex_redirect),
    .reserve_pc_i (fetch_pc_q),
    .fill_i       (keep_s & ~i_ex_redirect),
    .fill_inst_i  (i_imem_rdata),
    .pop_i        (o_if_valid & i_id_ready & ~i_ex_redirect),
    .head_valid_o (o_if_valid),
    .head_o       (head_s),
    .count_o      (queue_count_s)
  );

endmodule
